// File: rtl/text_writer.sv
// -----------------------------------------------------------------------------
// text_writer
//   Turns a stream of ASCII bytes into character-RAM writes for a COLS x ROWS
//   text screen. Bytes are buffered in a small FIFO, and each one is handled
//   in IDLE: printable characters, carriage return and backspace are acted on,
//   and any other byte is discarded. A line is cleared on every newline or
//   wrap. The whole screen is cleared after reset.
//
// Ports
//   clk         clock, rising-edge active
//   reset       asynchronous active-low reset
//   in_data     ASCII byte from the digest/keyboard stage
//   in_wren     one-cycle strobe, in_data valid when high
//   vram_addr   character RAM address {col[6:0], row[4:0]}
//   vram_data   character written to RAM
//   vram_we     one-cycle write strobe (addr/data hold while low)
//   cursor_col  cursor column, 0..COLS-1
//   cursor_row  cursor row, 0..ROWS-1
//   busy        high whenever the controller is not in IDLE
//   fifo_full   input buffer holds FIFO_DEPTH bytes
//   overflow    sticky: an input byte was dropped (cleared only by reset)
// -----------------------------------------------------------------------------
module text_writer #(
   parameter int unsigned COLS       = 70,
   parameter int unsigned ROWS       = 30,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  in_data,
   input  logic        in_wren,
   output logic [11:0] vram_addr,
   output logic [7:0]  vram_data,
   output logic        vram_we,
   output logic [6:0]  cursor_col,
   output logic [4:0]  cursor_row,
   output logic        busy,
   output logic        fifo_full,
   output logic        overflow
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
   localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);

   typedef enum logic [1:0] {
      S_CLR_ALL  = 2'd0,
      S_IDLE     = 2'd1,
      S_CLR_LINE = 2'd2
   } state_t;

   // ---------------------------------------------------------------- state
   state_t          r_state;
   logic [6:0]      r_col;
   logic [4:0]      r_row;
   logic [6:0]      r_clr_col;
   logic [4:0]      r_clr_row;
   logic            r_we;
   logic [11:0]     r_addr;
   logic [7:0]      r_data;
   logic            r_busy;
   logic            r_full;
   logic            r_ovf;
   logic [CW-1:0]   r_count;
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [7:0]      r_fifo [FIFO_DEPTH];

   // ---------------------------------------------------------------- next
   state_t          w_state_nxt;
   logic [6:0]      w_col_nxt;
   logic [4:0]      w_row_nxt;
   logic [6:0]      w_clr_col_nxt;
   logic [4:0]      w_clr_row_nxt;
   logic            w_we_nxt;
   logic [11:0]     w_addr_nxt;
   logic [7:0]      w_data_nxt;
   logic [CW-1:0]   w_count_nxt;
   logic [4:0]      w_row_inc;
   logic [7:0]      w_head;
   logic            w_pop;
   logic            w_push;
   logic            w_drop;

   // ---------------------------------------------------------------- FIFO
   assign w_head = r_fifo[r_rd_ptr];
   assign w_pop  = (r_state == S_IDLE) && (r_count != '0);
   // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
   assign w_push = in_wren && (!r_full || w_pop);
   assign w_drop = in_wren && r_full && !w_pop;
   assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo[r_wr_ptr] <= in_data;
      end
   end

   // ---------------------------------------------------------------- control
   assign w_row_inc = (r_row == LAST_ROW) ? '0 : r_row + 5'd1;

   always_comb begin
      w_state_nxt   = r_state;
      w_col_nxt     = r_col;
      w_row_nxt     = r_row;
      w_clr_col_nxt = r_clr_col;
      w_clr_row_nxt = r_clr_row;
      w_we_nxt      = 1'b0;
      w_addr_nxt    = r_addr;
      w_data_nxt    = r_data;

      case (r_state)
         S_CLR_ALL: begin
            w_we_nxt   = 1'b1;
            w_addr_nxt = {r_clr_col, r_clr_row};
            w_data_nxt = '0;
            if (r_clr_col == LAST_COL) begin
               w_clr_col_nxt = '0;
               if (r_clr_row == LAST_ROW) begin
                  w_clr_row_nxt = '0;
                  w_state_nxt   = S_IDLE;
               end else begin
                  w_clr_row_nxt = r_clr_row + 5'd1;
               end
            end else begin
               w_clr_col_nxt = r_clr_col + 7'd1;
            end
         end

         S_CLR_LINE: begin
            // Cursor row already points at the line being cleared.
            w_we_nxt   = 1'b1;
            w_addr_nxt = {r_clr_col, r_row};
            w_data_nxt = '0;
            if (r_clr_col == LAST_COL) begin
               w_clr_col_nxt = '0;
               w_state_nxt   = S_IDLE;
            end else begin
               w_clr_col_nxt = r_clr_col + 7'd1;
            end
         end

         S_IDLE: begin
            if (w_pop) begin
               if ((w_head >= 8'h20) && (w_head <= 8'h7E)) begin
                  w_we_nxt   = 1'b1;
                  w_addr_nxt = {r_col, r_row};
                  w_data_nxt = w_head;
                  if (r_col == LAST_COL) begin
                     w_col_nxt     = '0;
                     w_row_nxt     = w_row_inc;
                     w_clr_col_nxt = '0;
                     w_state_nxt   = S_CLR_LINE;
                  end else begin
                     w_col_nxt = r_col + 7'd1;
                  end
               end else if (w_head == 8'h0D) begin
                  w_col_nxt     = '0;
                  w_row_nxt     = w_row_inc;
                  w_clr_col_nxt = '0;
                  w_state_nxt   = S_CLR_LINE;
               end else if (w_head == 8'h08) begin
                  if (r_col != '0) begin
                     w_col_nxt  = r_col - 7'd1;
                     w_we_nxt   = 1'b1;
                     w_addr_nxt = {r_col - 7'd1, r_row};
                     w_data_nxt = '0;
                  end else if (r_row != '0) begin
                     w_col_nxt  = LAST_COL;
                     w_row_nxt  = r_row - 5'd1;
                     w_we_nxt   = 1'b1;
                     w_addr_nxt = {LAST_COL, r_row - 5'd1};
                     w_data_nxt = '0;
                  end
               end
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_CLR_ALL;
         r_col     <= '0;
         r_row     <= '0;
         r_clr_col <= '0;
         r_clr_row <= '0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_data    <= '0;
         r_busy    <= 1'b1;
         r_full    <= 1'b0;
         r_ovf     <= 1'b0;
         r_count   <= '0;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_col     <= w_col_nxt;
         r_row     <= w_row_nxt;
         r_clr_col <= w_clr_col_nxt;
         r_clr_row <= w_clr_row_nxt;
         r_we      <= w_we_nxt;
         r_addr    <= w_addr_nxt;
         r_data    <= w_data_nxt;
         r_busy    <= (w_state_nxt != S_IDLE);
         r_full    <= (w_count_nxt == CW'(FIFO_DEPTH));
         r_count   <= w_count_nxt;
         if (w_drop) begin
            r_ovf <= 1'b1;
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
      end
   end

   assign vram_addr  = r_addr;
   assign vram_data  = r_data;
   assign vram_we    = r_we;
   assign cursor_col = r_col;
   assign cursor_row = r_row;
   assign busy       = r_busy;
   assign fifo_full  = r_full;
   assign overflow   = r_ovf;

endmodule
